// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM arbiter state encoding, grant selectors,
// memory geometry and opcode constants.
package cpu_pkg;

  localparam int ADDR_W      = 16;
  localparam int FETCH_BYTES = 4;
  localparam int K_W         = $clog2(FETCH_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_TAIL = 3'd2,
    ST_DRD        = 3'd3,
    ST_DRD_CAP    = 3'd4,
    ST_DWR        = 3'd5
  } arb_state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam logic [7:0] OPCODE_NOP  = 8'h00;
  localparam logic [7:0] OPCODE_LOAD = 8'h01;
  localparam logic [7:0] OPCODE_STOR = 8'h02;
  localparam logic [7:0] OPCODE_ADD  = 8'h03;
  localparam logic [7:0] OPCODE_JMP  = 8'h05;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: fetch burst port and data byte port.
interface ram_arbiter_if;
  import cpu_pkg::*;

  logic                     fetch_req;
  logic [ADDR_W-1:0]        fetch_addr;
  logic                     fetch_ack;
  logic [8*FETCH_BYTES-1:0] fetch_data;
  logic                     data_req;
  logic                     data_we;
  logic [ADDR_W-1:0]        data_addr;
  logic [7:0]               data_wdata;
  logic                     data_ack;
  logic [7:0]               data_rdata;

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    input  fetch_ack, fetch_data, data_ack, data_rdata
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    output fetch_ack, fetch_data, data_ack, data_rdata
  );

endinterface

// File: rtl/ram_arb_pick.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module ram_arb_pick
  import cpu_pkg::*;
(
  input  logic i_req_fetch,
  input  logic i_req_data,
  input  logic i_last_grant,
  output logic o_grant
);

  // Grant select; only meaningful when at least one request is present
  always_comb begin
    o_grant = GNT_FETCH;
    if (i_req_fetch && i_req_data) begin
      o_grant = (i_last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (i_req_data) begin
      o_grant = GNT_DATA;
    end else begin
      o_grant = GNT_FETCH;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter/sequencer: pipelined multi-byte instruction fetch
// and single-byte data read/write over one registered-output RAM.
module ram_arbiter
  import cpu_pkg::*;
(
  input  logic              ram_clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data_in,
  input  logic [7:0]        ram_data_out,
  output logic              busy
);

  localparam logic [K_W-1:0] K_LAST = K_W'(FETCH_BYTES - 1);

  arb_state_t               r_state, w_state_nxt;
  logic [K_W-1:0]           r_k, w_k_nxt;
  logic [ADDR_W-1:0]        r_addr, w_addr_nxt;
  logic [7:0]               r_din, w_din_nxt;
  logic                     r_we, w_we_nxt;
  logic                     r_fetch_ack, w_fetch_ack_nxt;
  logic                     r_data_ack, w_data_ack_nxt;
  logic [8*FETCH_BYTES-1:0] r_fetch_data, w_fetch_data_nxt;
  logic [7:0]               r_rdata, w_rdata_nxt;
  logic                     r_last_grant, w_last_grant_nxt;
  logic                     r_busy;
  logic                     w_req_fetch, w_req_data, w_grant;
  logic                     w_cap_en;
  logic [K_W-1:0]           w_cap_idx;

  // Requests are masked in any ack cycle so a late-dropping requester is not re-granted
  assign w_req_fetch = bus.fetch_req & ~(r_fetch_ack | r_data_ack);
  assign w_req_data  = bus.data_req  & ~(r_fetch_ack | r_data_ack);

  ram_arb_pick u_pick (
    .i_req_fetch  (w_req_fetch),
    .i_req_data   (w_req_data),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Next-state, address sequencing and capture selection
  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_addr_nxt       = r_addr;
    w_din_nxt        = r_din;
    w_we_nxt         = 1'b0;
    w_fetch_ack_nxt  = 1'b0;
    w_data_ack_nxt   = 1'b0;
    w_rdata_nxt      = r_rdata;
    w_last_grant_nxt = r_last_grant;
    w_cap_en         = 1'b0;
    w_cap_idx        = '0;
    w_fetch_data_nxt = r_fetch_data;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fetch || w_req_data) begin
          w_last_grant_nxt = w_grant;
          if (w_grant == GNT_FETCH) begin
            w_addr_nxt  = bus.fetch_addr;
            w_k_nxt     = '0;
            w_state_nxt = ST_FETCH;
          end else begin
            w_addr_nxt = bus.data_addr;
            if (bus.data_we) begin
              w_din_nxt   = bus.data_wdata;
              w_we_nxt    = 1'b1;
              w_state_nxt = ST_DWR;
            end else begin
              w_state_nxt = ST_DRD;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // r_k is the byte whose address is on the RAM; byte r_k-1 arrives now
        if (r_k != '0) begin
          w_cap_en  = 1'b1;
          w_cap_idx = r_k - K_W'(1);
        end else begin
          w_cap_en = 1'b0;
        end
        if (r_k != K_LAST) begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_k_nxt    = r_k + K_W'(1);
        end else begin
          w_state_nxt = ST_FETCH_TAIL;
        end
      end
      ST_FETCH_TAIL: begin
        w_cap_en        = 1'b1;
        w_cap_idx       = K_LAST;
        w_k_nxt         = '0;
        w_fetch_ack_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
      ST_DRD: begin
        w_state_nxt = ST_DRD_CAP;
      end
      ST_DRD_CAP: begin
        w_rdata_nxt    = ram_data_out;
        w_data_ack_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_DWR: begin
        w_data_ack_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    for (int b = 0; b < FETCH_BYTES; b++) begin
      if (w_cap_en && (int'(w_cap_idx) == b)) begin
        w_fetch_data_nxt[8*b +: 8] = ram_data_out;
      end else begin
        w_fetch_data_nxt[8*b +: 8] = r_fetch_data[8*b +: 8];
      end
    end
  end

  // State and output registers
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_addr       <= '0;
      r_din        <= 8'h00;
      r_we         <= 1'b0;
      r_fetch_ack  <= 1'b0;
      r_data_ack   <= 1'b0;
      r_fetch_data <= '0;
      r_rdata      <= 8'h00;
      r_last_grant <= GNT_FETCH;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_addr       <= w_addr_nxt;
      r_din        <= w_din_nxt;
      r_we         <= w_we_nxt;
      r_fetch_ack  <= w_fetch_ack_nxt;
      r_data_ack   <= w_data_ack_nxt;
      r_fetch_data <= w_fetch_data_nxt;
      r_rdata      <= w_rdata_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign ram_write_enable = r_we;
  assign ram_address      = r_addr;
  assign ram_data_in      = r_din;
  assign busy             = r_busy;
  assign bus.fetch_ack    = r_fetch_ack;
  assign bus.fetch_data   = r_fetch_data;
  assign bus.data_ack     = r_data_ack;
  assign bus.data_rdata   = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM.
module tb_ram_arbiter;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        busy;
  logic [7:0]  mem [0:65535];

  int n_checks;
  int n_errors;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .ram_clk          (clk),
    .rst              (rst),
    .bus              (bus),
    .ram_write_enable (ram_we),
    .ram_address      (ram_addr),
    .ram_data_in      (ram_din),
    .ram_data_out     (ram_dout),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read data
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge; lat = cycles from grant edge to ack cycle, -1 on timeout
  task automatic run_fetch(input logic [15:0] addr, output int lat,
                           output logic we_seen, output logic [31:0] data);
    lat = -1;
    we_seen = 1'b0;
    data = 32'h0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ram_we) we_seen = 1'b1;
      if (bus.fetch_ack) begin
        lat  = n - 1;
        data = bus.fetch_data;
        break;
      end
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic run_data(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic we_hi);
    lat = -1;
    rd = 8'h00;
    we_hi = 1'b0;
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) we_hi = ram_we;
      if (bus.data_ack) begin
        lat = n - 1;
        rd  = bus.data_rdata;
        break;
      end
    end
    bus.data_req = 1'b0;
  endtask

  int          lat;
  logic        wes;
  logic [31:0] fd;
  logic [7:0]  rd;
  int          n_d1, n_d2, n_f;
  logic [7:0]  rd1, rd2;
  logic        reraised;
  logic        spurious;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = 16'h0000;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = 16'h0000; bus.data_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h05; mem[16'h0002] = 8'h00; mem[16'h0003] = 8'h00;
    mem[16'h0030] = 8'h3C; mem[16'h0031] = 8'hC3;
    mem[16'h0040] = 8'h10; mem[16'h0041] = 8'h20; mem[16'h0042] = 8'h30; mem[16'h0043] = 8'h40;
    mem[16'h0100] = 8'hDE; mem[16'h0101] = 8'hAD; mem[16'h0102] = 8'hBE; mem[16'h0103] = 8'hEF;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    do_reset();

    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fack", {31'd0, bus.fetch_ack}, 32'd0);
    check("rst_dack", {31'd0, bus.data_ack}, 32'd0);
    check("rst_fdata", bus.fetch_data, 32'd0);
    check("rst_rdata", {24'd0, bus.data_rdata}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_addr", {16'd0, ram_addr}, 32'd0);
    check("rst_din", {24'd0, ram_din}, 32'd0);

    // Fetch only
    run_fetch(16'h0000, lat, wes, fd);
    check("fetch_lat", lat, 32'd5);
    check("fetch_data", fd, 32'h00000501);
    check("fetch_no_we", {31'd0, wes}, 32'd0);

    // Write then read back
    @(negedge clk);
    run_data(1'b1, 16'h0010, 8'hAB, lat, rd, wes);
    check("wr_lat", lat, 32'd1);
    check("wr_we_hi", {31'd0, wes}, 32'd1);
    @(negedge clk);
    check("wr_we_low", {31'd0, ram_we}, 32'd0);
    check("idle_addr_hold", {16'd0, ram_addr}, 32'h0010);
    run_data(1'b0, 16'h0010, 8'h00, lat, rd, wes);
    check("rd_lat", lat, 32'd2);
    check("rd_data", {24'd0, rd}, 32'h000000AB);
    check("rd_no_we", {31'd0, wes}, 32'd0);
    @(negedge clk);
    check("rdata_hold", {24'd0, bus.data_rdata}, 32'h000000AB);

    // Tie after reset: data wins; data re-requests and the repeated tie goes to fetch
    do_reset();
    @(negedge clk);
    n_d1 = -1; n_d2 = -1; n_f = -1; rd1 = 8'h00; rd2 = 8'h00; fd = 32'h0; reraised = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0040;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 16'h0030;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.data_ack) begin
        if (n_d1 < 0) begin n_d1 = n; rd1 = bus.data_rdata; end
        else begin n_d2 = n; rd2 = bus.data_rdata; end
        bus.data_req = 1'b0;
      end else if (n_d1 >= 0 && n_d2 < 0 && !reraised) begin
        reraised = 1'b1;
        bus.data_req = 1'b1;
        bus.data_addr = 16'h0031;
      end
      if (bus.fetch_ack) begin
        n_f = n; fd = bus.fetch_data; bus.fetch_req = 1'b0;
      end
      if (n_d2 >= 0 && n_f >= 0) break;
    end
    bus.data_req = 1'b0; bus.fetch_req = 1'b0;
    check("tie_data_first", n_d1, 32'd3);
    check("tie_rd1", {24'd0, rd1}, 32'h0000003C);
    check("tie_fetch_ack", n_f, 32'd10);
    check("tie_fetch_data", fd, 32'h40302010);
    check("tie_data_second", n_d2, 32'd14);
    check("tie_rd2", {24'd0, rd2}, 32'h000000C3);

    // Address wrap
    @(negedge clk);
    mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    run_fetch(16'hFFFE, lat, wes, fd);
    check("wrap_lat", lat, 32'd5);
    check("wrap_data", fd, 32'h44332211);

    // Reset sampled at E2 of a fetch
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_addr", {16'd0, ram_addr}, 32'd0);
    check("mrst_fdata", bus.fetch_data, 32'd0);
    spurious = bus.fetch_ack;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.fetch_ack || busy) spurious = 1'b1;
    end
    check("mrst_no_ack", {31'd0, spurious}, 32'd0);
    run_fetch(16'h0100, lat, wes, fd);
    check("post_rst_lat", lat, 32'd5);
    check("post_rst_data", fd, 32'hEFBEADDE);

    // Requester holds req past ack: no grant in the ack cycle, then a fresh grant
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 16'h0020; bus.data_wdata = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    check("hold_ack", {31'd0, bus.data_ack}, 32'd1);
    @(negedge clk);
    check("hold_no_regrant", {31'd0, busy}, 32'd0);
    check("hold_no_ack2", {31'd0, bus.data_ack}, 32'd0);
    @(negedge clk);
    check("hold_new_grant", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("hold_new_ack", {31'd0, bus.data_ack}, 32'd1);
    bus.data_req = 1'b0;
    @(negedge clk);
    run_data(1'b0, 16'h0020, 8'h00, lat, rd, wes);
    check("hold_readback", {24'd0, rd}, 32'h0000005A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter and sequencer sharing the `ram` instance between the instruction-fetch requester (stage12) and the data requester (stage3). Instruction fetch is a pipelined multi-byte burst read; data accesses are a single byte, read or write. Each requester uses a req/ack handshake. The arbiter alone drives the RAM's `write_enable`, `address` and `data_in`, and accounts for the RAM's registered one-cycle read latency.

## Interface
- `ADDR_W`, 16, RAM address width.
- `FETCH_BYTES`, 4, bytes per instruction fetch burst.
- `ram_clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch request, held until `fetch_ack`.
- `fetch_addr`  in  ADDR_W  burst start address, stable while `fetch_req` is high.
- `fetch_ack`  out  1  one-cycle pulse; `fetch_data` is valid in that cycle.
- `fetch_data`  out  8*FETCH_BYTES  byte k = mem[addr+k] at bits [8k+7:8k].
- `data_req`  in  1  data request, held until `data_ack`.
- `data_we`  in  1  1 = write, 0 = read; stable with `data_req`.
- `data_addr`  in  ADDR_W  byte address.
- `data_wdata`  in  8  write byte.
- `data_ack`  out  1  one-cycle completion pulse.
- `data_rdata`  out  8  read byte, valid in the `data_ack` cycle; holds its value afterwards.
- `ram_write_enable`  out  1  to `ram.write_enable`.
- `ram_address`  out  ADDR_W  to `ram.address`.
- `ram_data_in`  out  8  to `ram.data_in`.
- `ram_data_out`  in  8  from `ram.data_out`, registered in the RAM.
- `busy`  out  1  high in every non-IDLE state.

## Operation
- States:
  - IDLE: arbitrates.
  - FETCH: issues byte addresses, count k = 0..FETCH_BYTES-1.
  - FETCH_TAIL: last capture.
  - DRD: data read, address issued.
  - DRD_CAP: captures the read byte.
  - DWR: write issued.
- Arbitration happens in IDLE only, one request per grant.
  - If one request is pending, grant it.
  - If both are pending, grant round-robin: the requester not granted last.
  - `last_grant` resets to FETCH, so data wins the first tie.
- Inputs are latched at the grant edge. Later changes to addr, we or wdata are ignored until ack.
- FETCH: the address for byte k is `fetch_addr + k` mod 2^ADDR_W, so 0xFFFF wraps to 0x0000. Byte k is captured from `ram_data_out` two edges after its address is registered.
- `ram_write_enable` is 1 only in DWR and is 0 in every read state, so the RAM never writes during a fetch.
- In IDLE, `ram_address` and `ram_data_in` hold their last values and `ram_write_enable` is 0.
- A requester must drop its req in the cycle its ack is high. The arbiter ignores both reqs in any cycle where either ack is high. This prevents a double grant.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - k = 0;
  - `last_grant` = FETCH.

## Timing
- The grant edge is E0, where req is seen high in IDLE.
- Fetch:
  - Address A+k is registered at edge Ek, for k = 0..3.
  - Byte k is captured at edge E(k+2).
  - `fetch_ack` is registered at E5 and is high in the cycle after E5.
  - Latency is 5 cycles from the grant edge; state returns to IDLE at E5.
- Data read:
  - Address is registered at E0.
  - `data_rdata` and `data_ack` are registered at E2, giving 2 cycles.
- Data write:
  - Address, wdata and we=1 are registered at E0; the RAM writes at E1.
  - `data_ack` is registered at E1 and we=0 at E1, giving 1 cycle.
- Earliest next grant is the edge after the ack cycle.
- Simultaneous reqs at E0 are resolved by round-robin. The loser waits; no request is dropped.
- Reset mid-operation:
  - At the reset edge, go to IDLE and force all outputs to reset values. No ack is issued.
  - A write registered at the edge before reset still completes in RAM at the reset edge, but is not acked.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding (IDLE, FETCH, FETCH_TAIL, DRD, DRD_CAP, DWR);
  - the grant constants GNT_FETCH and GNT_DATA;
  - ADDR_W, FETCH_BYTES, and the existing OPCODE_* defines.
- One sub-module, `ram_arb_pick`: a combinational 2-way round-robin picker.
  - Inputs: two reqs and `last_grant`.
  - Output: grant select.
- The FSM, address counter and capture registers live in `ram_arbiter`.

## Test plan
- Fetch only: mem[0..3] = 01 05 00 00, fetch_req with addr 0 → `fetch_ack` 5 cycles after grant, `fetch_data` = 0x00000501, `ram_write_enable` 0 throughout.
- Write then read: data write 0xAB to 0x0010 → `data_ack` after 1 cycle; then read 0x0010 → `data_ack` after 2 cycles with `data_rdata` = 0xAB.
- Simultaneous fetch and data read at the same edge after reset → data acked first, fetch granted the edge after `data_ack`. Repeat the tie → fetch wins.
- Wrap: fetch at 0xFFFE with mem[FFFE, FFFF, 0000, 0001] = 11 22 33 44 → `fetch_data` = 0x44332211.
- Reset asserted at E2 of a fetch → next cycle busy=0 and all outputs 0, no `fetch_ack`; a new fetch then completes normally.
- Requester holds req one cycle past ack → no second grant in the ack cycle. A req still high afterwards is treated as a new request.
